// File: rtl/hazard_control_unit.sv
// Hazard controller for the 5-stage MIPS core: load-use and branch-operand stalls,
// redirect flush, multi-cycle data-memory freeze and a stall watchdog.
// Optional HAZARD_PERF_CNT_EN adds saturating performance counters.
module hazard_control_unit #(
  parameter int STALL_TIMEOUT = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_uses_rs,
  input  logic       id_uses_rt,
  input  logic       id_is_branch,
  input  logic       id_branch_taken,
  input  logic       id_is_jump,
  input  logic       ex_reg_write,
  input  logic       ex_mem_read,
  input  logic [4:0] ex_rd,
  input  logic       mem_mem_read,
  input  logic [4:0] mem_rd,
  input  logic       dmem_start,
  input  logic       dmem_done,
  output logic       stall,
  output logic       stall_beq,
  output logic       jump_delect_pre_inst,
  output logic       pc_write,
  output logic       id_ex_bubble,
  output logic       id_ex_hold,
  output logic       hazard_timeout,
`ifdef HAZARD_PERF_CNT_EN
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_beq_cycles,
  output logic [31:0] perf_flush_count,
`endif
  output logic       debug_state
);

  typedef enum logic {
    RUN  = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

  localparam int WD_W = $clog2(STALL_TIMEOUT) + 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(STALL_TIMEOUT);

  mem_state_t state;
  mem_state_t state_next;
  logic       freeze;

  logic ex_match;
  logic mem_match;
  logic raw_stall;
  logic raw_beq;
  logic redirect;

  logic [WD_W-1:0] wd_count;
  logic [WD_W-1:0] wd_next;

  // r0 is hardwired to zero, so it can never be a real producer.
  function automatic logic reg_match(input logic [4:0] r, input logic [4:0] rs,
                                     input logic use_rs, input logic [4:0] rt,
                                     input logic use_rt);
    reg_match = (r != 5'd0) && (((r == rs) && use_rs) || ((r == rt) && use_rt));
  endfunction

  always_comb begin
    ex_match  = reg_match(ex_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);
    mem_match = reg_match(mem_rd, id_rs, id_uses_rs, id_rt, id_uses_rt);
    raw_stall = ex_mem_read && ex_match;
    raw_beq   = id_is_branch && ((ex_reg_write && ex_match) || (mem_mem_read && mem_match));
    redirect  = id_is_jump || (id_is_branch && id_branch_taken);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Next state and all pipeline controls; done in RUN is deliberately ignored.
  always_comb begin
    state_next           = state;
    freeze               = 1'b0;
    stall                = 1'b0;
    stall_beq            = 1'b0;
    jump_delect_pre_inst = 1'b0;
    pc_write             = 1'b1;
    id_ex_bubble         = 1'b0;
    id_ex_hold           = 1'b0;

    case (state)
      RUN: begin
        if (dmem_start) begin
          state_next = WAIT;
          freeze     = 1'b1;
        end
      end
      WAIT: begin
        if (dmem_done && !dmem_start) begin
          state_next = RUN;
        end
        freeze = !dmem_done;
      end
      default: state_next = RUN;
    endcase

    if (freeze) begin
      stall      = 1'b1;
      id_ex_hold = 1'b1;
      pc_write   = 1'b0;
    end else if (raw_beq) begin
      stall_beq    = 1'b1;
      id_ex_bubble = 1'b1;
      pc_write     = 1'b0;
    end else if (raw_stall) begin
      stall        = 1'b1;
      id_ex_bubble = 1'b1;
      pc_write     = 1'b0;
    end else begin
      // The PC still loads the redirect target while the fetched slot is flushed.
      jump_delect_pre_inst = redirect;
    end
  end

  assign debug_state = state;

  always_comb begin
    wd_next = wd_count;
    if (pc_write) begin
      wd_next = '0;
    end else if (wd_count != WD_LIMIT) begin
      wd_next = wd_count + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wd_count       <= '0;
      hazard_timeout <= 1'b0;
    end else begin
      wd_count <= wd_next;
      if (wd_next == WD_LIMIT) begin
        hazard_timeout <= 1'b1;
      end
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_beq_cycles   <= '0;
      perf_flush_count  <= '0;
    end else begin
      if (stall && (perf_stall_cycles != '1)) begin
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      end
      if (stall_beq && (perf_beq_cycles != '1)) begin
        perf_beq_cycles <= perf_beq_cycles + 32'd1;
      end
      if (jump_delect_pre_inst && (perf_flush_count != '1)) begin
        perf_flush_count <= perf_flush_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed bench for hazard_control_unit: hand-computed control vectors per cycle.
// Vector layout: {stall, stall_beq, flush, pc_write, id_ex_bubble, id_ex_hold, hazard_timeout}.
module tb_hazard_control_unit;

  logic       clock;
  logic       reset;
  logic [4:0] id_rs, id_rt;
  logic       id_uses_rs, id_uses_rt;
  logic       id_is_branch, id_branch_taken, id_is_jump;
  logic       ex_reg_write, ex_mem_read;
  logic [4:0] ex_rd;
  logic       mem_mem_read;
  logic [4:0] mem_rd;
  logic       dmem_start, dmem_done;
  logic       stall, stall_beq, jump_delect_pre_inst, pc_write;
  logic       id_ex_bubble, id_ex_hold, hazard_timeout;
  logic       debug_state;
`ifdef HAZARD_PERF_CNT_EN
  logic [31:0] perf_stall_cycles, perf_beq_cycles, perf_flush_count;
`endif

  int n_vec = 0;
  int n_mis = 0;

  localparam logic [6:0] V_IDLE   = 7'b0001000;
  localparam logic [6:0] V_LDUSE  = 7'b1000100;
  localparam logic [6:0] V_BEQ    = 7'b0100100;
  localparam logic [6:0] V_FLUSH  = 7'b0011000;
  localparam logic [6:0] V_FREEZE = 7'b1000010;

  hazard_control_unit #(.STALL_TIMEOUT(64)) dut (
    .clock(clock), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt),
    .id_is_branch(id_is_branch), .id_branch_taken(id_branch_taken), .id_is_jump(id_is_jump),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_mem_read(mem_mem_read), .mem_rd(mem_rd),
    .dmem_start(dmem_start), .dmem_done(dmem_done),
    .stall(stall), .stall_beq(stall_beq), .jump_delect_pre_inst(jump_delect_pre_inst),
    .pc_write(pc_write), .id_ex_bubble(id_ex_bubble), .id_ex_hold(id_ex_hold),
    .hazard_timeout(hazard_timeout),
`ifdef HAZARD_PERF_CNT_EN
    .perf_stall_cycles(perf_stall_cycles), .perf_beq_cycles(perf_beq_cycles),
    .perf_flush_count(perf_flush_count),
`endif
    .debug_state(debug_state)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic [6:0] exp);
    check(tag, {25'd0, stall, stall_beq, jump_delect_pre_inst, pc_write,
                id_ex_bubble, id_ex_hold, hazard_timeout}, {25'd0, exp});
  endtask

  // Inputs change 1 time unit after the posedge; checks sample mid-cycle.
  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    id_rs = 5'd0; id_rt = 5'd0; id_uses_rs = 1'b0; id_uses_rt = 1'b0;
    id_is_branch = 1'b0; id_branch_taken = 1'b0; id_is_jump = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b0; mem_rd = 5'd0;
    dmem_start = 1'b0; dmem_done = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    check_outs("reset_idle", V_IDLE);
    check("reset_state", {31'd0, debug_state}, 32'd0);

    // Load-use on rs: exactly one stall cycle.
    next_cycle();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd5;
    id_rs = 5'd5; id_uses_rs = 1'b1;
    #1 check_outs("load_use", V_LDUSE);
    next_cycle();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd5;
    #1 check_outs("load_use_release", V_IDLE);

    // Same load targeting r0: never a hazard.
    next_cycle();
    idle_inputs();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd0;
    id_uses_rs = 1'b1; id_rs = 5'd0;
    #1 check_outs("load_r0", V_IDLE);

    // Load-use outranks a jump: no flush while stalling.
    next_cycle();
    idle_inputs();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd9;
    id_rt = 5'd9; id_uses_rt = 1'b1; id_is_jump = 1'b1;
    #1 check_outs("load_use_vs_jump", V_LDUSE);

    // Branch after load: two stall_beq cycles, then the taken branch flushes.
    next_cycle();
    idle_inputs();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd8;
    id_is_branch = 1'b1; id_rt = 5'd8; id_uses_rt = 1'b1; id_rs = 5'd3; id_uses_rs = 1'b1;
    #1 check_outs("beq_load_ex", V_BEQ);
    next_cycle();
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_mem_read = 1'b1; mem_rd = 5'd8;
    #1 check_outs("beq_load_mem", V_BEQ);
    next_cycle();
    mem_mem_read = 1'b0; mem_rd = 5'd8; id_branch_taken = 1'b1;
    #1 check_outs("beq_taken_flush", V_FLUSH);

    // Branch after an ALU producer: one stall_beq cycle only.
    next_cycle();
    idle_inputs();
    ex_reg_write = 1'b1; ex_rd = 5'd12;
    id_is_branch = 1'b1; id_rs = 5'd12; id_uses_rs = 1'b1;
    #1 check_outs("beq_alu_ex", V_BEQ);
    next_cycle();
    ex_reg_write = 1'b0; ex_rd = 5'd0; mem_rd = 5'd12;
    #1 check_outs("beq_alu_release", V_IDLE);

    // Branch reading r0 with an r0 producer in EX.
    next_cycle();
    idle_inputs();
    ex_reg_write = 1'b1; ex_rd = 5'd0;
    id_is_branch = 1'b1; id_uses_rs = 1'b1; id_branch_taken = 1'b1;
    #1 check_outs("beq_r0_taken", V_FLUSH);

    // Plain jump.
    next_cycle();
    idle_inputs();
    id_is_jump = 1'b1;
    #1 check_outs("jump", V_FLUSH);

    // Multi-cycle access: freeze from the start cycle up to the done cycle.
    next_cycle();
    idle_inputs();
    dmem_start = 1'b1;
    #1 check_outs("dmem_c10", V_FREEZE);
    next_cycle();
    dmem_start = 1'b0;
    #1 check_outs("dmem_c11", V_FREEZE);
    check("dmem_state_wait", {31'd0, debug_state}, 32'd1);
    next_cycle();
    id_is_branch = 1'b1; id_branch_taken = 1'b1;
    #1 check_outs("dmem_c12_taken", V_FREEZE);
    next_cycle();
    ex_reg_write = 1'b1; ex_mem_read = 1'b1; ex_rd = 5'd4;
    id_rs = 5'd4; id_uses_rs = 1'b1;
    #1 check_outs("dmem_c13_hazard", V_FREEZE);
    next_cycle();
    idle_inputs();
    dmem_done = 1'b1;
    #1 check_outs("dmem_c14_done", V_IDLE);
    next_cycle();
    dmem_done = 1'b1;
    #1 check_outs("done_in_run_ignored", V_IDLE);
    next_cycle();
    idle_inputs();
    #1 check_outs("after_dmem_idle", V_IDLE);

    // Watchdog: start with no done; timeout after 64 stalled cycles, sticky.
    for (int i = 0; i < 64; i++) begin
      next_cycle();
      dmem_start = (i == 0);
      #1;
      if (i == 63) check_outs("wd_63", V_FREEZE);
    end
    next_cycle();
    dmem_start = 1'b0;
    #1 check_outs("wd_64", V_FREEZE | 7'b0000001);
    next_cycle();
    dmem_done = 1'b1;
    #1 check_outs("wd_sticky_done", V_IDLE | 7'b0000001);
    next_cycle();
    dmem_done = 1'b0;
    #1 check_outs("wd_sticky_idle", V_IDLE | 7'b0000001);
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    #1 check_outs("wd_cleared_by_reset", V_IDLE);

    // Reset during WAIT, then a stale done must not matter.
    next_cycle();
    dmem_start = 1'b1;
    next_cycle();
    dmem_start = 1'b0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    dmem_done = 1'b1;
    #1 check_outs("reset_mid_wait", V_IDLE);
    check("reset_mid_wait_state", {31'd0, debug_state}, 32'd0);
    next_cycle();
    dmem_done = 1'b0;
    #1 check_outs("post_reset_run", V_IDLE);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish, observed running expected done");
    $fatal(1, "bench time limit");
  end

endmodule
